// File: rtl/counter_arbiter.sv
// Shared WIDTH-bit up/down/load counter, serviced one operation per prescaler tick.
// Requesters are picked round-robin; a requester holding req_lock keeps ownership across ticks.
module counter_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int DIV   = 2,
  localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic [N-1:0]         req_valid,
  input  logic [2*N-1:0]       req_op,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_lock,
  output logic [N-1:0]         req_ready,
  output logic [WIDTH-1:0]     value,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, OWNED} state_t;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_INC = 2'b01, OP_DEC = 2'b10, OP_LOAD = 2'b11} op_t;

  state_t           state, state_n;
  logic [DCW-1:0]   div_cnt;
  logic             tick;
  logic [IDW-1:0]   last, owner, owner_n;
  logic [IDW-1:0]   win, idx;
  logic             found, xfer;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] data_sel;

  // With DIV=1 the counter stays at 0, which equals DIV-1, so tick is constantly high.
  assign tick = (div_cnt == DCW'(DIV - 1));

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_)   div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Candidate selection: the owner alone while OWNED, else first valid after last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    if (state == OWNED) begin
      found = req_valid[owner];
      win   = owner;
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        idx = IDW'((32'(last) + k) % N);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
  end

  assign xfer = reset_ && tick && found;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N; i++)
      req_ready[i] = xfer && (32'(win) == i);
  end

  always_comb begin
    op_sel   = req_op[2*win +: 2];
    data_sel = req_data[WIDTH*win +: WIDTH];
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    if (tick) begin
      case (state)
        IDLE: begin
          if (found && req_lock[win]) begin
            state_n = OWNED;
            owner_n = win;
          end
        end
        OWNED: begin
          // Owner silent on a tick, or its unlocked op accepted: give the counter back.
          if (!found || !req_lock[owner]) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      owner       <= '0;
      last        <= IDW'(N - 1);
      value       <= '1;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      grant_valid <= xfer;
      if (xfer) begin
        last     <= win;
        grant_id <= win;
        case (op_sel)
          OP_INC:  value <= value + 1'b1;
          OP_DEC:  value <= value - 1'b1;
          OP_LOAD: value <= data_sel;
          default: value <= value;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Randomized bench for counter_arbiter: a behavioural model predicts each grant,
// and a separate monitor checks the registered grant/value against a scoreboard queue.
module tb_counter_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int DIV   = 2;
  localparam int IDW   = 2;

  logic               clock = 1'b0;
  logic               reset_;
  logic [N-1:0]       req_valid;
  logic [2*N-1:0]     req_op;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_lock;
  logic [N-1:0]       req_ready;
  logic [WIDTH-1:0]   value;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;

  counter_arbiter #(.N(N), .WIDTH(WIDTH), .DIV(DIV)) dut (
    .clock       (clock),
    .reset_      (reset_),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .value       (value),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t sb[$];

  // Reference model state: tick phase, rotation pointer, ownership, counter value.
  int               m_cyc;
  int               m_last;
  bit               m_owned;
  int               m_owner;
  logic [WIDTH-1:0] m_value;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_last  = N - 1;
    m_owned = 0;
    m_owner = 0;
    m_value = '1;
    sb.delete();
  endtask

  // Evaluate one clock cycle of the spec with the inputs currently applied.
  task automatic model_step(output int w);
    logic [N-1:0]     exp_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] d;
    w = -1;
    if ((m_cyc % DIV) == DIV - 1) begin
      if (m_owned) begin
        if (req_valid[m_owner]) w = m_owner;
        else m_owned = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
        end
      end
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("ready", req_ready, exp_ready);
    if (w >= 0) begin
      op = req_op[2*w +: 2];
      d  = req_data[WIDTH*w +: WIDTH];
      case (op)
        2'b01:   m_value = m_value + 1;
        2'b10:   m_value = m_value - 1;
        2'b11:   m_value = d;
        default: ;
      endcase
      m_last  = w;
      m_owned = req_lock[w];
      m_owner = w;
      sb.push_back('{id: w, val: m_value});
    end
    m_cyc++;
  endtask

  task automatic new_req(input int i, input int mode);
    logic [WIDTH-1:0] d;
    case ($urandom_range(0, 3))
      0:       d = '0;
      1:       d = 8'hFE;
      2:       d = '1;
      default: d = WIDTH'($urandom);
    endcase
    req_data[WIDTH*i +: WIDTH] = d;
    case (mode)
      0: begin req_valid[i] = 1'b0; req_op[2*i +: 2] = 2'b00; req_lock[i] = 1'b0; end
      1: begin req_valid[i] = 1'b1; req_op[2*i +: 2] = 2'b01; req_lock[i] = 1'b0; end
      2: begin
        req_valid[i]      = 1'($urandom_range(0, 1));
        req_op[2*i +: 2]  = 2'($urandom_range(0, 3));
        req_lock[i]       = ($urandom_range(0, 2) == 0);
      end
      default: begin
        req_valid[i]      = ($urandom_range(0, 3) != 0);
        req_op[2*i +: 2]  = 2'($urandom_range(0, 3));
        req_lock[i]       = ($urandom_range(0, 2) != 0);
      end
    endcase
  endtask

  // Accepted or idle requesters may take a new request; pending ones stay frozen.
  task automatic cycle(input int mode);
    int w;
    @(negedge clock);
    model_step(w);
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++)
      if (i == w || !req_valid[i]) new_req(i, mode);
  endtask

  task automatic run(input int n, input int mode);
    repeat (n) cycle(mode);
  endtask

  always @(negedge clock) begin
    if (reset_ === 1'b1 && grant_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("grant_id", grant_id, e.id);
        check("value", value, e.val);
      end
    end
  end

  initial begin
    bit got_owner;
    reset_    = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    req_lock  = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_value", value, 8'hFF);
    check("reset_ready", req_ready, 0);
    check("reset_grant_valid", grant_valid, 0);
    check("reset_grant_id", grant_id, 0);
    @(posedge clock);
    #1;
    reset_ = 1'b1;
    model_reset();

    run(10, 0);
    check("idle_value", value, 8'hFF);
    run(20, 1);
    run(300, 2);
    run(300, 3);

    // Reset in the middle of a locked burst.
    got_owner = 0;
    for (int c = 0; c < 400 && !got_owner; c++) begin
      cycle(3);
      got_owner = m_owned;
    end
    check("owner_seen", got_owner, 1);
    @(negedge clock);
    #2;
    reset_ = 1'b0;
    #1;
    check("midreset_value", value, 8'hFF);
    check("midreset_ready", req_ready, 0);
    check("midreset_grant_valid", grant_valid, 0);
    for (int i = 0; i < N; i++) new_req(i, 1);
    @(posedge clock);
    #1;
    reset_ = 1'b1;
    model_reset();
    run(12, 1);
    run(200, 2);

    run(40, 0);
    check("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
Shares one WIDTH-bit up/down/load counter between N requesters. Operations are issued only on prescaler ticks, one every DIV clocks. A round-robin arbiter picks one requester per tick. A requester can lock ownership across consecutive ticks to run bursts. The block sits between the input-event sources (mouse, keys, host writes) and the counter value consumers.

Parameters:
N, 4, number of requesters (2..16)
WIDTH, 8, counter and load-data width
DIV, 2, clocks per operation tick (>=1; 1 = every clock)

Ports:
clock  input  1  single system clock; all state on posedge
reset_  input  1  asynchronous, active-low reset
req_valid  input  N  bit i: requester i has an operation pending
req_op  input  2*N  op of requester i at [2i+1:2i]: 00 nop, 01 inc, 10 dec, 11 load
req_data  input  N*WIDTH  load value of requester i at [WIDTH*i+WIDTH-1:WIDTH*i]
req_lock  input  N  bit i: requester i holds ownership after its accepted op
req_ready  output  N  one-hot; op of requester i accepted this cycle
value  output  WIDTH  current counter value
grant_valid  output  1  registered pulse: an op was accepted last cycle
grant_id  output  clog2(N) (min 1)  registered index of last accepted requester

Behaviour:
- Reset (reset_ low, async): value = all ones; div_cnt = 0; state = IDLE; last = N-1, so requester 0 has first priority; owner = 0; grant_valid = 0; grant_id = 0. req_ready is 0 while reset_ is low.
- Prescaler: div_cnt counts 0..DIV-1 and wraps. tick = (div_cnt == DIV-1). For DIV=1, tick is constantly 1. The prescaler runs freely, independent of requests.
- req_ready is combinational. It is zero unless tick is high and a winner exists. A transfer happens when req_valid[i] and req_ready[i] are both high. At most one bit of req_ready is ever set.
- States:
  - IDLE: the winner is the first valid requester scanning last+1, last+2, ... modulo N.
  - OWNED: the only candidate is owner.
- Transitions, evaluated on a tick:
  - IDLE to OWNED: accepted winner w has req_lock[w]=1. Set owner=w.
  - OWNED to OWNED: owner accepted and req_lock[owner]=1.
  - OWNED to IDLE: owner accepted with req_lock=0. Also OWNED to IDLE, with no transfer that tick, when req_valid[owner]=0 on a tick.
- Every accepted transfer sets last = accepted index, including transfers in OWNED.
- While OWNED, other requesters get no grant on any tick.
- Op effect, applied on the clock edge ending the accepting cycle:
  - inc: value = value+1, modulo 2^WIDTH (all ones wraps to 0).
  - dec: value = value-1 (0 wraps to all ones).
  - load: value = req_data slice.
  - nop: value unchanged, but the transfer still counts for grant, lock and rotation.
- Registered outputs: grant_valid and grant_id update on the same edge as value. grant_valid is high for exactly one cycle per transfer; grant_id holds its value between transfers.
- Requests that are not accepted remain pending. Requesters must hold valid, op, data and lock stable until ready.
- Asynchronous reset mid-burst drops ownership and restores all reset values immediately. The first tick after reset_ rises occurs DIV cycles later.

Test Plan:
- Reset and idle: N=4, WIDTH=8, DIV=2, no requests. Required: value=0xFF; req_ready is never set; tick occurs every 2nd clock.
- Round-robin: all 4 requesters valid with inc held for 4 ticks. Required: grants go 0,1,2,3; value goes 0xFF, 0x00, 0x01, 0x02, 0x03; grant_valid pulses once every 2 clocks.
- Wrap and load: requester 2 loads 0x00, then decs. Required: value 0x00 then 0xFF. Requester 1 loads 0xFE then incs twice. Required: value 0xFE, 0xFF, 0x00.
- Lock burst: requester 3 with lock=1 and inc for 3 ops while requesters 0 and 1 stay valid. Required: three consecutive grants to 3 (ids 3,3,3). Lock then drops with a final op: that op is granted to 3; the next grant goes to 0.
- Owner abandon: requester 1 locks, then drops valid. Required: the next tick grants nothing and returns to IDLE; the following tick grants requester 2 when requesters 2 and 0 are both valid.
- Mid-op reset: assert reset_ low during an OWNED burst at value 0x42. Required: value is 0xFF immediately; req_ready=0; after release, the first grant goes to requester 0 when all are valid, 2 clocks later.
